// File: rtl/sw_run_ctrl.sv
//------------------------------------------------------------------------------
// sw_run_ctrl : run-level sequencer for the Smith-Waterman accelerator.
// Rev 1.0 : load-T / calculate sequencing, watchdog, best-score reduction.
//------------------------------------------------------------------------------
`default_nettype none

module sw_run_ctrl #(
  parameter int VEF_BIT     = 10,
  parameter int MATCH_BIT   = 4,
  parameter int ACK_TIMEOUT = 16,
  parameter int CLR_CYCLES  = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               i_set_t,
  input  logic               i_start_cal,
  input  logic [MATCH_BIT-1:0] i_match,
  input  logic [MATCH_BIT-1:0] i_mismatch,
  input  logic [7:0]         i_minusAlpha,
  input  logic [7:0]         i_minusBeta,
  input  logic               i_param_valid,
  input  logic               i_sram_busy,
  input  logic               i_pe_busy,
  input  logic [VEF_BIT-1:0] i_pe_result,
  input  logic               i_pe_valid,
  output logic               o_start_read_t,
  output logic               o_start_cal,
  output logic               o_clr,
  output logic [VEF_BIT-1:0] o_post_match,
  output logic [VEF_BIT-1:0] o_post_mismatch,
  output logic [VEF_BIT-1:0] o_post_alpha,
  output logic [VEF_BIT-1:0] o_post_beta,
  output logic               o_busy_w,
  output logic [VEF_BIT-1:0] o_result,
  output logic               o_valid,
  output logic               o_err
);

  localparam int WD_W  = $clog2(ACK_TIMEOUT + 1);
  localparam int CLR_W = $clog2(CLR_CYCLES + 1);
  localparam logic [WD_W-1:0]  WD_LAST  = WD_W'(ACK_TIMEOUT - 1);
  localparam logic [CLR_W-1:0] CLR_LAST = CLR_W'(CLR_CYCLES - 1);

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_SETT_ACK = 3'd1,
    ST_SETT_RUN = 3'd2,
    ST_CALC_ACK = 3'd3,
    ST_CALC_RUN = 3'd4,
    ST_CLEAR    = 3'd5
  } state_t;

  state_t              state_q;
  logic                t_loaded_q;
  logic                param_ok_q;
  logic [WD_W-1:0]     wd_q;
  logic [CLR_W-1:0]    clr_cnt_q;
  logic [VEF_BIT-1:0]  best_q;
  logic [VEF_BIT-1:0]  best_d;
  logic [VEF_BIT-1:0]  result_q;
  logic [VEF_BIT-1:0]  post_match_q;
  logic [VEF_BIT-1:0]  post_mismatch_q;
  logic [VEF_BIT-1:0]  post_alpha_q;
  logic [VEF_BIT-1:0]  post_beta_q;
  logic                start_read_t_q;
  logic                start_cal_q;
  logic                clr_q;
  logic                valid_q;
  logic                err_q;

  // Folding the current beat into the max lets the final beat of a run,
  // arriving together with the busy fall, still reach o_result.
  assign best_d = (i_pe_valid && (i_pe_result > best_q)) ? i_pe_result : best_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q         <= ST_IDLE;
      t_loaded_q      <= 1'b0;
      param_ok_q      <= 1'b0;
      wd_q            <= '0;
      clr_cnt_q       <= '0;
      best_q          <= '0;
      result_q        <= '0;
      post_match_q    <= '0;
      post_mismatch_q <= '0;
      post_alpha_q    <= '0;
      post_beta_q     <= '0;
      start_read_t_q  <= 1'b0;
      start_cal_q     <= 1'b0;
      clr_q           <= 1'b0;
      valid_q         <= 1'b0;
      err_q           <= 1'b0;
    end else begin
      start_read_t_q <= 1'b0;
      start_cal_q    <= 1'b0;
      valid_q        <= 1'b0;
      err_q          <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (i_param_valid) begin
            post_match_q    <= VEF_BIT'(i_match);
            post_mismatch_q <= VEF_BIT'(i_mismatch);
            post_alpha_q    <= VEF_BIT'(i_minusAlpha);
            post_beta_q     <= VEF_BIT'(i_minusBeta);
            param_ok_q      <= 1'b1;
          end
          if (i_set_t) begin
            if (!i_sram_busy) begin
              start_read_t_q <= 1'b1;
              t_loaded_q     <= 1'b0;
              wd_q           <= '0;
              state_q        <= ST_SETT_ACK;
            end
          end else if (i_start_cal) begin
            if (!(t_loaded_q && param_ok_q)) begin
              err_q <= 1'b1;
            end else if (!i_pe_busy) begin
              start_cal_q <= 1'b1;
              best_q      <= '0;
              wd_q        <= '0;
              state_q     <= ST_CALC_ACK;
            end
          end
        end
        ST_SETT_ACK: begin
          if (i_sram_busy) begin
            wd_q    <= '0;
            state_q <= ST_SETT_RUN;
          end else if (wd_q == WD_LAST) begin
            err_q   <= 1'b1;
            wd_q    <= '0;
            state_q <= ST_IDLE;
          end else begin
            wd_q <= wd_q + WD_W'(1);
          end
        end
        ST_SETT_RUN: begin
          if (!i_sram_busy) begin
            t_loaded_q <= 1'b1;
            state_q    <= ST_IDLE;
          end
        end
        ST_CALC_ACK: begin
          best_q <= best_d;
          if (i_pe_busy) begin
            wd_q    <= '0;
            state_q <= ST_CALC_RUN;
          end else if (wd_q == WD_LAST) begin
            err_q   <= 1'b1;
            wd_q    <= '0;
            state_q <= ST_IDLE;
          end else begin
            wd_q <= wd_q + WD_W'(1);
          end
        end
        ST_CALC_RUN: begin
          best_q <= best_d;
          if (!i_pe_busy) begin
            result_q  <= best_d;
            valid_q   <= 1'b1;
            clr_q     <= 1'b1;
            clr_cnt_q <= '0;
            state_q   <= ST_CLEAR;
          end
        end
        ST_CLEAR: begin
          if (clr_cnt_q == CLR_LAST) begin
            clr_q     <= 1'b0;
            clr_cnt_q <= '0;
            state_q   <= ST_IDLE;
          end else begin
            clr_cnt_q <= clr_cnt_q + CLR_W'(1);
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign o_start_read_t  = start_read_t_q;
  assign o_start_cal     = start_cal_q;
  assign o_clr           = clr_q;
  assign o_valid         = valid_q;
  assign o_err           = err_q;
  assign o_result        = result_q;
  assign o_post_match    = post_match_q;
  assign o_post_mismatch = post_mismatch_q;
  assign o_post_alpha    = post_alpha_q;
  assign o_post_beta     = post_beta_q;
  assign o_busy_w        = (state_q != ST_IDLE) | i_sram_busy | i_pe_busy;

endmodule

`default_nettype wire

// File: tb/tb_sw_run_ctrl.sv
//------------------------------------------------------------------------------
// tb_sw_run_ctrl : self-checking bench for sw_run_ctrl with SRAM/PE models.
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_sw_run_ctrl;

  localparam int VEF_BIT = 10;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic i_set_t = 1'b0, i_start_cal = 1'b0, i_param_valid = 1'b0;
  logic [3:0] i_match = '0, i_mismatch = '0;
  logic [7:0] i_minusAlpha = '0, i_minusBeta = '0;
  logic i_sram_busy = 1'b0, i_pe_busy = 1'b0, i_pe_valid = 1'b0;
  logic [VEF_BIT-1:0] i_pe_result = '0;
  logic o_start_read_t, o_start_cal, o_clr, o_busy_w, o_valid, o_err;
  logic [VEF_BIT-1:0] o_post_match, o_post_mismatch, o_post_alpha, o_post_beta, o_result;

  sw_run_ctrl #(.VEF_BIT(VEF_BIT), .MATCH_BIT(4), .ACK_TIMEOUT(16), .CLR_CYCLES(2)) u_dut (
    .clk(clk), .rst(rst),
    .i_set_t(i_set_t), .i_start_cal(i_start_cal),
    .i_match(i_match), .i_mismatch(i_mismatch),
    .i_minusAlpha(i_minusAlpha), .i_minusBeta(i_minusBeta),
    .i_param_valid(i_param_valid),
    .i_sram_busy(i_sram_busy), .i_pe_busy(i_pe_busy),
    .i_pe_result(i_pe_result), .i_pe_valid(i_pe_valid),
    .o_start_read_t(o_start_read_t), .o_start_cal(o_start_cal), .o_clr(o_clr),
    .o_post_match(o_post_match), .o_post_mismatch(o_post_mismatch),
    .o_post_alpha(o_post_alpha), .o_post_beta(o_post_beta),
    .o_busy_w(o_busy_w), .o_result(o_result), .o_valid(o_valid), .o_err(o_err)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Pulse/strobe counters sampled on the falling edge
  int n_srt = 0, n_scal = 0, n_errp = 0, n_clr = 0, n_val = 0;
  logic [VEF_BIT-1:0] exp_q[$];

  always @(negedge clk) begin
    if (o_start_read_t) n_srt++;
    if (o_start_cal)    n_scal++;
    if (o_err)          n_errp++;
    if (o_clr)          n_clr++;
    if (o_valid) begin
      n_val++;
      if (exp_q.size() == 0) chk("unexpected_valid", 1, 0);
      else chk("result", 32'(o_result), 32'(exp_q.pop_front()));
    end
  end

  // SRAM model: busy rises 3 cycles after the pulse and stays 10 cycles
  logic sram_en = 1'b1;
  always @(negedge clk) begin
    if (o_start_read_t && sram_en) begin
      repeat (3) @(negedge clk);
      i_sram_busy = 1'b1;
      repeat (10) @(negedge clk);
      i_sram_busy = 1'b0;
    end
  end

  // PE model: busy for 20 cycles, up to three results at fixed slots
  int pe_vals[3];
  int pe_n = 0;
  always @(negedge clk) begin
    if (o_start_cal) begin
      automatic int m = 0;
      automatic bit aborted = 1'b0;
      for (int j = 0; j < pe_n; j++) if (pe_vals[j] > m) m = pe_vals[j];
      exp_q.push_back(VEF_BIT'(m));
      repeat (2) @(negedge clk);
      i_pe_busy = 1'b1;
      for (int i = 0; i < 20; i++) begin
        @(negedge clk);
        if (rst) begin
          aborted = 1'b1;
          break;
        end
        i_pe_valid = 1'b0;
        for (int j = 0; j < pe_n; j++) begin
          if (i == 3 + 4 * j) begin
            i_pe_valid  = 1'b1;
            i_pe_result = VEF_BIT'(pe_vals[j]);
          end
        end
      end
      i_pe_valid = 1'b0;
      i_pe_busy  = 1'b0;
      if (aborted) exp_q.delete();
    end
  end

  task automatic wait_idle(input string tag);
    int k;
    for (k = 0; k < 80; k++) begin
      tick();
      if (!o_busy_w) break;
    end
    if (k == 80) chk({tag, "_idle_timeout"}, 0, 1);
  endtask

  task automatic check_params(input string tag, input int m, input int mm, input int a, input int b);
    chk({tag, "_match"},    32'(o_post_match),    m);
    chk({tag, "_mismatch"}, 32'(o_post_mismatch), mm);
    chk({tag, "_alpha"},    32'(o_post_alpha),    a);
    chk({tag, "_beta"},     32'(o_post_beta),     b);
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_start_read_t"}, 32'(o_start_read_t), 0);
    chk({tag, "_start_cal"},    32'(o_start_cal),    0);
    chk({tag, "_clr"},          32'(o_clr),          0);
    chk({tag, "_valid"},        32'(o_valid),        0);
    chk({tag, "_err"},          32'(o_err),          0);
    chk({tag, "_result"},       32'(o_result),       0);
    check_params(tag, 0, 0, 0, 0);
  endtask

  task automatic run_calc(input string tag, input bit strobe_mid);
    int v0, c0, s0;
    v0 = n_val; c0 = n_clr; s0 = n_scal;
    i_start_cal = 1'b1;
    tick();
    i_start_cal = 1'b0;
    chk({tag, "_start_cal_pulse"}, 32'(o_start_cal), 1);
    if (strobe_mid) begin
      repeat (8) tick();
      i_match = 4'd9; i_mismatch = 4'd9; i_minusAlpha = 8'd99; i_minusBeta = 8'd77;
      i_param_valid = 1'b1;
      tick();
      i_param_valid = 1'b0;
    end
    wait_idle(tag);
    tick();
    chk({tag, "_valid_pulses"}, n_val - v0, 1);
    chk({tag, "_clr_cycles"},   n_clr - c0, 2);
    chk({tag, "_start_cal_cnt"}, n_scal - s0, 1);
    chk({tag, "_sb_empty"},     exp_q.size(), 0);
  endtask

  initial begin
    int k, s0, c0, e0;
    repeat (3) tick();
    chk("reset_busy", 32'(o_busy_w), 0);
    check_zero("reset");
    rst = 1'b0;
    tick();

    // Calculate before any load
    e0 = n_errp; c0 = n_scal;
    i_start_cal = 1'b1;
    tick();
    i_start_cal = 1'b0;
    chk("noload_err", 32'(o_err), 1);
    chk("noload_start_cal", 32'(o_start_cal), 0);
    tick();
    chk("noload_err_one_cycle", n_errp - e0, 1);
    chk("noload_no_cal", n_scal - c0, 0);

    // Parameters
    i_match = 4'd3; i_mismatch = 4'd2; i_minusAlpha = 8'd5; i_minusBeta = 8'd1;
    i_param_valid = 1'b1;
    tick();
    i_param_valid = 1'b0;
    check_params("param", 3, 2, 5, 1);

    // Load T with a simultaneous calculate request
    s0 = n_srt; c0 = n_scal; e0 = n_errp;
    i_set_t = 1'b1; i_start_cal = 1'b1;
    tick();
    i_set_t = 1'b0; i_start_cal = 1'b0;
    chk("load_start_read_t", 32'(o_start_read_t), 1);
    chk("load_no_start_cal", 32'(o_start_cal), 0);
    for (k = 1; k <= 40; k++) begin
      tick();
      if (!o_busy_w) break;
    end
    chk("load_idle_cycle", k, 14);
    chk("load_srt_pulses", n_srt - s0, 1);
    chk("load_cal_pulses", n_scal - c0, 0);
    chk("load_no_err", n_errp - e0, 0);

    // Three calculations without reloading T
    pe_vals = '{7, 12, 9};   pe_n = 3;
    run_calc("calc1", 1'b0);
    chk("calc1_hold_result", 32'(o_result), 12);
    pe_n = 0;
    run_calc("calc_empty", 1'b0);
    pe_vals = '{1023, 5, 600}; pe_n = 3;
    run_calc("calc_max", 1'b1);
    check_params("param_ignored", 3, 2, 5, 1);

    // Watchdog on a load that never acknowledges
    sram_en = 1'b0;
    i_set_t = 1'b1;
    tick();
    i_set_t = 1'b0;
    for (k = 1; k <= 40; k++) begin
      tick();
      if (o_err) break;
    end
    chk("wd_err_cycle", k, 16);
    chk("wd_idle", 32'(o_busy_w), 0);
    i_start_cal = 1'b1;
    tick();
    i_start_cal = 1'b0;
    chk("wd_then_cal_err", 32'(o_err), 1);
    chk("wd_then_no_cal", 32'(o_start_cal), 0);
    sram_en = 1'b1;

    // Reload, then reset in the middle of a calculation
    i_set_t = 1'b1;
    tick();
    i_set_t = 1'b0;
    wait_idle("reload");
    pe_vals = '{40, 50, 60}; pe_n = 3;
    i_start_cal = 1'b1;
    tick();
    i_start_cal = 1'b0;
    repeat (8) tick();
    chk("midrun_busy", 32'(o_busy_w), 1);
    #2 rst = 1'b1;
    #1 check_zero("async_reset");
    repeat (3) tick();
    rst = 1'b0;
    tick();
    chk("post_reset_busy", 32'(o_busy_w), 0);
    chk("post_reset_sb_empty", exp_q.size(), 0);
    i_start_cal = 1'b1;
    tick();
    i_start_cal = 1'b0;
    chk("post_reset_cal_err", 32'(o_err), 1);
    chk("post_reset_no_cal", 32'(o_start_cal), 0);
    repeat (3) tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "simulation time limit");
  end

endmodule

`default_nettype wire
